// File: rtl/encoder_4to2_sync_if.sv
// Request/response bundle for encoder_4to2_sync: one-hot request lines in,
// a 2-bit code out through a valid/ready output register.
interface encoder_4to2_sync_if;
  logic en;
  logic y0;
  logic y1;
  logic y2;
  logic y3;
  logic ready;
  logic a;
  logic b;
  logic valid;

  // The master drives requests and consumes codes. The slave is the encoder.
  modport master (
    output en, y0, y1, y2, y3, ready,
    input  a, b, valid
  );

  modport slave (
    input  en, y0, y1, y2, y3, ready,
    output a, b, valid
  );
endinterface

// File: rtl/encoder_4to2_sync.sv
// Registered 4-to-2 priority encoder with a valid/ready output register,
// sticky multi-hot/overflow flags and a saturating accepted-event counter.
module encoder_4to2_sync #(
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  encoder_4to2_sync_if.slave    bus,
  input  logic                  clr,
  output logic                  multi_err,
  output logic                  ovf,
  output logic [CNT_W-1:0]      evt_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t      state_q, state_d;
  logic [3:0]  req;
  logic        evt;
  logic        multi_hot;
  logic [1:0]  code;
  logic        load;
  logic        drop;
  logic [1:0]  code_q;

  assign req = {bus.y3, bus.y2, bus.y1, bus.y0};
  assign evt = bus.en && (req != 4'b0000);

  // Two or more lines high: clearing the lowest set bit leaves something.
  assign multi_hot = (req & (req - 4'd1)) != 4'b0000;

  // NOTE: every signal gets a default before the if/else chain, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    code = 2'd0;
    if (req[3])      code = 2'd3;
    else if (req[2]) code = 2'd2;
    else if (req[1]) code = 2'd1;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (evt) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (bus.ready) begin
          if (evt) load    = 1'b1;
          else     state_d = EMPTY;
        end else if (evt) begin
          drop = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      if (load) code_q <= code;
    end
  end

  // clr wins over a same-cycle set or increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multi_err <= 1'b0;
      ovf       <= 1'b0;
      evt_cnt   <= '0;
    end else if (clr) begin
      multi_err <= 1'b0;
      ovf       <= 1'b0;
      evt_cnt   <= '0;
    end else begin
      if (evt && multi_hot)          multi_err <= 1'b1;
      if (drop)                      ovf       <= 1'b1;
      if (load && evt_cnt != CNT_MAX) evt_cnt  <= evt_cnt + 1'b1;
    end
  end

  assign bus.a     = code_q[0];
  assign bus.b     = code_q[1];
  assign bus.valid = (state_q == FULL);

  // A stalled code must stay put until the consumer takes it.
  a_hold_when_stalled : assert property (
    @(posedge clk) disable iff (!rst_n)
    (bus.valid && !bus.ready) |=> (bus.valid && $stable(code_q))
  );

endmodule

// File: tb/tb_encoder_4to2_sync.sv
// Self-checking bench for encoder_4to2_sync: a code scoreboard plus a small
// flag/counter model, with a second CNT_W=2 instance for saturation.
module tb_encoder_4to2_sync;

  logic clk;
  logic rst_n;
  logic clr;
  logic multi_err;
  logic ovf;
  logic [7:0] evt_cnt;

  logic clr2;
  logic multi_err2;
  logic ovf2;
  logic [1:0] evt_cnt2;

  int total;
  int bad;

  // Expected-state model for the CNT_W=8 instance.
  logic       m_valid;
  logic       m_multi;
  logic       m_ovf;
  logic [7:0] m_cnt;
  logic [1:0] sb[$];

  encoder_4to2_sync_if bus ();
  encoder_4to2_sync_if bus2 ();

  encoder_4to2_sync #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clr       (clr),
    .multi_err (multi_err),
    .ovf       (ovf),
    .evt_cnt   (evt_cnt)
  );

  encoder_4to2_sync #(.CNT_W(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus2),
    .clr       (clr2),
    .multi_err (multi_err2),
    .ovf       (ovf2),
    .evt_cnt   (evt_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic model_clear();
    m_valid = 1'b0;
    m_multi = 1'b0;
    m_ovf   = 1'b0;
    m_cnt   = 8'd0;
    sb.delete();
  endtask

  // One clock of stimulus on the main instance, then compare at the falling edge.
  task automatic step(input logic e, input logic [3:0] y, input logic rdy,
                      input logic c, input string tag);
    logic       ev, ld, xfer, drop;
    logic [1:0] code;
    bus.en = e;
    bus.y0 = y[0];
    bus.y1 = y[1];
    bus.y2 = y[2];
    bus.y3 = y[3];
    bus.ready = rdy;
    clr = c;
    ev   = e && (y != 4'b0000);
    code = y[3] ? 2'd3 : y[2] ? 2'd2 : y[1] ? 2'd1 : 2'd0;
    xfer = m_valid && rdy;
    ld   = ev && (!m_valid || rdy);
    drop = ev && m_valid && !rdy;
    @(posedge clk);
    if (xfer && sb.size() > 0) void'(sb.pop_front());
    if (ld) sb.push_back(code);
    m_valid = ld ? 1'b1 : (xfer ? 1'b0 : m_valid);
    if (c) begin
      m_multi = 1'b0;
      m_ovf   = 1'b0;
      m_cnt   = 8'd0;
    end else begin
      if (ev && $countones(y) > 1) m_multi = 1'b1;
      if (drop) m_ovf = 1'b1;
      if (ld && m_cnt != 8'hff) m_cnt = m_cnt + 8'd1;
    end
    @(negedge clk);
    total++;
    if (bus.valid !== m_valid) begin
      bad++;
      $display("FAIL %s valid: got %b want %b", tag, bus.valid, m_valid);
    end
    if (m_valid && sb.size() > 0) begin
      total++;
      if ({bus.b, bus.a} !== sb[0]) begin
        bad++;
        $display("FAIL %s code: got %b want %b", tag, {bus.b, bus.a}, sb[0]);
      end
    end
    total++;
    if (multi_err !== m_multi) begin
      bad++;
      $display("FAIL %s multi_err: got %b want %b", tag, multi_err, m_multi);
    end
    total++;
    if (ovf !== m_ovf) begin
      bad++;
      $display("FAIL %s ovf: got %b want %b", tag, ovf, m_ovf);
    end
    total++;
    if (evt_cnt !== m_cnt) begin
      bad++;
      $display("FAIL %s evt_cnt: got %0d want %0d", tag, evt_cnt, m_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.en = 1'b0; bus.y0 = 1'b0; bus.y1 = 1'b0; bus.y2 = 1'b0; bus.y3 = 1'b0;
    bus.ready = 1'b0; clr = 1'b0;
    bus2.en = 1'b0; bus2.y0 = 1'b0; bus2.y1 = 1'b0; bus2.y2 = 1'b0; bus2.y3 = 1'b0;
    bus2.ready = 1'b0; clr2 = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    total++;
    if ({bus.valid, bus.b, bus.a, multi_err, ovf} !== 5'b0 || evt_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset: got v=%b ba=%b%b me=%b ovf=%b cnt=%0d want all 0",
               bus.valid, bus.b, bus.a, multi_err, ovf, evt_cnt);
    end
    total++;
    if (bus2.valid !== 1'b0 || evt_cnt2 !== 2'd0) begin
      bad++;
      $display("FAIL reset2: got v=%b cnt=%0d want 0 0", bus2.valid, evt_cnt2);
    end
    rst_n = 1'b1;
    step(1'b0, 4'b0000, 1'b0, 1'b0, "idle_after_reset");
  endtask

  task automatic test_one_hot();
    step(1'b1, 4'b0001, 1'b1, 1'b0, "y0");
    step(1'b1, 4'b0010, 1'b1, 1'b0, "y1");
    step(1'b1, 4'b0100, 1'b1, 1'b0, "y2");
    step(1'b1, 4'b1000, 1'b1, 1'b0, "y3");
    step(1'b0, 4'b0000, 1'b1, 1'b0, "drain");
    total++;
    if (evt_cnt !== 8'd4) begin
      bad++;
      $display("FAIL one_hot_count: got %0d want 4", evt_cnt);
    end
  endtask

  task automatic test_multi_hot();
    step(1'b1, 4'b1010, 1'b1, 1'b0, "y1y3");
    step(1'b0, 4'b0000, 1'b1, 1'b0, "multi_sticky0");
    step(1'b1, 4'b0001, 1'b1, 1'b0, "multi_sticky1");
    step(1'b0, 4'b0000, 1'b1, 1'b1, "multi_clr");
  endtask

  task automatic test_overflow();
    step(1'b1, 4'b0100, 1'b0, 1'b0, "stall_y2");
    step(1'b1, 4'b0010, 1'b0, 1'b0, "stall_y1_drop");
    step(1'b0, 4'b0000, 1'b0, 1'b0, "stall_hold");
    total++;
    if (ovf !== 1'b1 || evt_cnt !== 8'd1 || {bus.b, bus.a} !== 2'b10) begin
      bad++;
      $display("FAIL overflow: got ovf=%b cnt=%0d ba=%b%b want 1 1 10",
               ovf, evt_cnt, bus.b, bus.a);
    end
    step(1'b0, 4'b0000, 1'b1, 1'b0, "stall_release");
  endtask

  task automatic test_enable_low();
    for (int i = 0; i < 5; i++) step(1'b0, 4'b1000, 1'b1, 1'b0, "en_low");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, "random");
    end
    step(1'b0, 4'b0000, 1'b1, 1'b1, "random_drain");
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [6];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    bus2.ready = 1'b1;
    bus2.en    = 1'b1;
    bus2.y0    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (evt_cnt2 !== exp_cnt[i] || bus2.valid !== 1'b1 || {bus2.b, bus2.a} !== 2'b00) begin
        bad++;
        $display("FAIL sat[%0d]: got cnt=%0d v=%b ba=%b%b want %0d 1 00",
                 i, evt_cnt2, bus2.valid, bus2.b, bus2.a, exp_cnt[i]);
      end
    end
    clr2 = 1'b1;
    @(negedge clk);
    total++;
    if (evt_cnt2 !== 2'd0 || bus2.valid !== 1'b1 || multi_err2 !== 1'b0) begin
      bad++;
      $display("FAIL sat_clr: got cnt=%0d v=%b me=%b want 0 1 0",
               evt_cnt2, bus2.valid, multi_err2);
    end
    clr2    = 1'b0;
    bus2.en = 1'b0;
    bus2.y0 = 1'b0;
    @(negedge clk);
    total++;
    if (bus2.valid !== 1'b0) begin
      bad++;
      $display("FAIL sat_drain: got v=%b want 0", bus2.valid);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 4'b1000, 1'b0, 1'b0, "pre_rst_load");
    step(1'b1, 4'b0011, 1'b0, 1'b0, "pre_rst_drop");
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.valid, bus.b, bus.a, multi_err, ovf} !== 5'b0 || evt_cnt !== 8'd0) begin
      bad++;
      $display("FAIL async_reset: got v=%b ba=%b%b me=%b ovf=%b cnt=%0d want all 0",
               bus.valid, bus.b, bus.a, multi_err, ovf, evt_cnt);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 4'b0000, 1'b0, 1'b0, "post_rst_idle");
    step(1'b1, 4'b0100, 1'b1, 1'b0, "post_rst_event");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_one_hot();
    test_multi_hot();
    test_overflow();
    test_enable_low();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encoder_4to2_sync.md
Name: encoder_4to2_sync

Overview:
- Registered 4-to-2 priority encoder; the inverse of decoder_2to4.
- Samples one-hot request lines y0..y3 and returns the 2-bit code on a (LSB) and b (MSB).
- Presents each code to a downstream consumer through a valid/ready output register.
- Keeps sticky multi-hot and overflow error flags plus a saturating event counter, so decoder outputs can be looped back and checked.

Parameters:
- CNT_W, 8, width of evt_cnt; saturates at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  sample enable; y0..y3 are ignored when low
- y0  input  1  request line 0 (code a=0,b=0)
- y1  input  1  request line 1 (code a=1,b=0)
- y2  input  1  request line 2 (code a=0,b=1)
- y3  input  1  request line 3 (code a=1,b=1)
- ready  input  1  downstream accepts the held code when high with valid
- clr  input  1  synchronous clear of multi_err, ovf and evt_cnt
- a  output  1  code bit 0 (LSB)
- b  output  1  code bit 1 (MSB)
- valid  output  1  a/b hold an unconsumed code
- multi_err  output  1  sticky; a sampled event had more than one request line high
- ovf  output  1  sticky; an event was dropped because the output was full
- evt_cnt  output  CNT_W  number of events accepted into the output register

Behaviour:
- Reset: rst_n low asynchronously forces a=0, b=0, valid=0, multi_err=0, ovf=0, evt_cnt=0 and state EMPTY. This applies at any time, including mid-handshake; a held code is discarded.
- Event: en=1 and at least one of y0..y3 is high at a rising edge.
  - en=0, or all lines low, is not an event.
- Encoding is priority, highest index wins:
  - y3 gives b=1,a=1; else y2 gives b=1,a=0; else y1 gives b=0,a=1; else y0 gives 0,0.
- Latency: the code and valid appear one cycle after the sampling edge. There is no combinational path from y* to a/b.
- State machine, two states; valid=1 exactly in FULL.
  - EMPTY + event: load code -> FULL.
  - EMPTY + no event: stay EMPTY.
  - FULL + ready=1 + event: load new code, stay FULL. This is back-to-back, one code per cycle.
  - FULL + ready=1 + no event: -> EMPTY; a/b keep their last value.
  - FULL + ready=0: hold a/b stable. Any event in this state is dropped and sets ovf.
- Handshake: a transfer occurs on an edge with valid=1 and ready=1. ready while EMPTY has no effect. valid never drops without a transfer, except on reset.
- multi_err: set on any event with two or more lines high, including dropped events. The code still follows priority.
- evt_cnt:
  - +1 for each event loaded into the register.
  - Dropped events are not counted.
  - Holds at 2^CNT_W-1 with no wrap.
- clr:
  - On the edge, multi_err=0, ovf=0, evt_cnt=0.
  - clr takes precedence over a same-cycle set or increment: that event's error or count is lost.
  - clr does not affect valid, a, b or state; the event itself is still loaded if the state allows it.
- en low while FULL: the held code stays until a transfer.

Test Plan:
1. Reset, then en=1, ready=1, drive each of y0,y1,y2,y3 one-hot for one cycle each.
   -> Codes (b,a) = 00, 01, 10, 11 appear one cycle later, with valid high 4 consecutive cycles. evt_cnt=4, multi_err=0.
2. en=1, y1=1 and y3=1 together.
   -> b=1, a=1 one cycle later; multi_err=1 and stays 1 until clr, then 0.
3. ready=0; event y2, then event y1 on the next cycle.
   -> a=0, b=1, valid=1 held. ovf=1, evt_cnt=1. Raise ready with no event -> valid=0 the next cycle.
4. en=0 with y3=1 for 5 cycles.
   -> valid stays 0, evt_cnt unchanged.
5. CNT_W=2, ready=1, 6 consecutive y0 events.
   -> evt_cnt goes 1, 2, 3, 3, 3, 3. clr asserted together with a 7th event -> evt_cnt=0 and valid=1.
6. Assert rst_n low mid-cycle while FULL with ready=0.
   -> valid, a, b, flags and count go to 0 immediately, without waiting for a clock edge.
